// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute/memory/write-back sequencer for the 16-bit CPU.
// Define ILLEGAL_TRAP_EN to trap opcodes B-E into HALT with a sticky illegal_out flag.
module cpu_ctrl_fsm #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] instr_in,
   input  logic        z_in,
   input  logic        mem_ready_in,
   output logic        mem_req_out,
   output logic        mem_we_out,
   output logic        ir_load_out,
   output logic        pc_inc_out,
   output logic        pc_load_out,
   output logic [2:0]  alu_op_out,
   output logic [1:0]  mux_sel_out,
   output logic        rf_we_out,
   output logic        halted_out,
   output logic        bus_err_out,
   output logic        illegal_out,
   output logic [2:0]  state_out
);

   localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] C_TMO = CW'(MEM_TIMEOUT);
   localparam logic [CW-1:0] C_MAX = {CW{1'b1}};
   localparam logic C_TMO_EN = (MEM_TIMEOUT != 0);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [3:0]    r_opc;
   logic [CW-1:0] r_cnt;
   logic          r_bus_err;
   logic          w_set_be;
   logic          w_tmo;
   logic          w_is_alu;
   logic [2:0]    w_alu_code;
   logic          w_mem_req;
   logic          w_mem_we;
   logic          w_ir_load;
   logic          w_pc_inc;
   logic          w_pc_load;
   logic [2:0]    w_alu_op;
   logic [1:0]    w_mux_sel;
   logic          w_rf_we;
   logic          w_halted;
   logic          w_unused;

   assign w_unused   = ^instr_in[11:0];
   assign w_is_alu   = (r_opc >= 4'h1) && (r_opc <= 4'h5);
   assign w_alu_code = 3'(r_opc - 4'h1);
   // Ready wins over timeout: expiry only counts while the request is still unanswered.
   assign w_tmo      = C_TMO_EN && (r_cnt == C_TMO) && !mem_ready_in;

`ifdef ILLEGAL_TRAP_EN
   logic r_illegal;
   logic w_set_ill;
`endif

   // Next-state and control decode; Mealy fetch strobes depend on mem_ready_in.
   always_comb begin
      w_next    = r_state;
      w_set_be  = 1'b0;
      w_mem_req = 1'b0;
      w_mem_we  = 1'b0;
      w_ir_load = 1'b0;
      w_pc_inc  = 1'b0;
      w_pc_load = 1'b0;
      w_alu_op  = 3'b000;
      w_mux_sel = 2'b11;
      w_rf_we   = 1'b0;
      w_halted  = 1'b0;
`ifdef ILLEGAL_TRAP_EN
      w_set_ill = 1'b0;
`endif
      case (r_state)
         S_IDLE: w_next = S_FETCH;
         S_FETCH: begin
            w_mem_req = 1'b1;
            if (mem_ready_in) begin
               w_ir_load = 1'b1;
               w_pc_inc  = 1'b1;
               w_next    = S_DECODE;
            end else if (w_tmo) begin
               w_set_be = 1'b1;
               w_next   = S_HALT;
            end else begin
               w_next = S_FETCH;
            end
         end
         S_DECODE: w_next = S_EXEC;
         S_EXEC: begin
            case (r_opc)
               4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
                  w_alu_op = w_alu_code;
                  w_next   = S_WB;
               end
               4'h6: w_next = S_WB;
               4'h7, 4'h8: w_next = S_MEM;
               4'h9: begin
                  w_pc_load = 1'b1;
                  w_next    = S_FETCH;
               end
               4'hA: begin
                  w_pc_load = z_in;
                  w_next    = S_FETCH;
               end
               4'hF: w_next = S_HALT;
               4'h0: w_next = S_FETCH;
               default: begin
`ifdef ILLEGAL_TRAP_EN
                  w_set_ill = 1'b1;
                  w_next    = S_HALT;
`else
                  w_next = S_FETCH;
`endif
               end
            endcase
         end
         S_MEM: begin
            w_mem_req = 1'b1;
            w_mem_we  = (r_opc == 4'h8);
            if (mem_ready_in) begin
               w_next = (r_opc == 4'h7) ? S_WB : S_FETCH;
            end else if (w_tmo) begin
               w_set_be = 1'b1;
               w_next   = S_HALT;
            end else begin
               w_next = S_MEM;
            end
         end
         S_WB: begin
            w_rf_we = 1'b1;
            w_next  = S_FETCH;
            if (w_is_alu) begin
               w_alu_op  = w_alu_code;
               w_mux_sel = 2'b00;
            end else if (r_opc == 4'h7) begin
               w_mux_sel = 2'b01;
            end else if (r_opc == 4'h6) begin
               w_mux_sel = 2'b10;
            end else begin
               w_mux_sel = 2'b11;
            end
         end
         S_HALT: begin
            w_halted = 1'b1;
            w_next   = S_HALT;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // State, latched opcode and sticky bus-error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_opc     <= 4'h0;
         r_bus_err <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE) begin
            r_opc <= instr_in[15:12];
         end else begin
            r_opc <= r_opc;
         end
         r_bus_err <= r_bus_err | w_set_be;
      end
   end

   // Wait counter restarts whenever the state changes, so each FETCH/MEM entry begins at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= {CW{1'b0}};
      end else if (w_next != r_state) begin
         r_cnt <= {CW{1'b0}};
      end else if (w_mem_req && !mem_ready_in && (r_cnt != C_MAX)) begin
         r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
      end else begin
         r_cnt <= r_cnt;
      end
   end

`ifdef ILLEGAL_TRAP_EN
   // Sticky illegal-opcode flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_illegal <= 1'b0;
      end else begin
         r_illegal <= r_illegal | w_set_ill;
      end
   end
   assign illegal_out = r_illegal;
`else
   assign illegal_out = 1'b0;
`endif

   assign mem_req_out = w_mem_req;
   assign mem_we_out  = w_mem_we;
   assign ir_load_out = w_ir_load;
   assign pc_inc_out  = w_pc_inc;
   assign pc_load_out = w_pc_load;
   assign alu_op_out  = w_alu_op;
   assign mux_sel_out = w_mux_sel;
   assign rf_we_out   = w_rf_we;
   assign halted_out  = w_halted;
   assign bus_err_out = r_bus_err;
   assign state_out   = r_state;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm (MEM_TIMEOUT=4): stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares the full output vector.
module tb_cpu_ctrl_fsm;

   logic        clk;
   logic        rst_n;
   logic [15:0] instr_in;
   logic        z_in;
   logic        mem_ready_in;
   logic        mem_req_out, mem_we_out, ir_load_out, pc_inc_out, pc_load_out;
   logic [2:0]  alu_op_out;
   logic [1:0]  mux_sel_out;
   logic        rf_we_out, halted_out, bus_err_out, illegal_out;
   logic [2:0]  state_out;

   cpu_ctrl_fsm #(.MEM_TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .z_in(z_in),
      .mem_ready_in(mem_ready_in), .mem_req_out(mem_req_out), .mem_we_out(mem_we_out),
      .ir_load_out(ir_load_out), .pc_inc_out(pc_inc_out), .pc_load_out(pc_load_out),
      .alu_op_out(alu_op_out), .mux_sel_out(mux_sel_out), .rf_we_out(rf_we_out),
      .halted_out(halted_out), .bus_err_out(bus_err_out), .illegal_out(illegal_out),
      .state_out(state_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [16:0] v;
      string       nm;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          failures = 0;
   logic        rst_drv = 1'b0;
   logic [15:0] cur_i = 16'h0000;
   logic        cur_z = 1'b0;
   logic        fbe = 1'b0;
   logic        fill = 1'b0;

   // Vector layout: state, req, we, ir_load, pc_inc, pc_load, alu_op, mux_sel, rf_we, halted, bus_err, illegal
   wire [16:0] act = {state_out, mem_req_out, mem_we_out, ir_load_out, pc_inc_out, pc_load_out,
                      alu_op_out, mux_sel_out, rf_we_out, halted_out, bus_err_out, illegal_out};

   function automatic logic [16:0] ev(input logic [2:0] st, input logic [4:0] c,
                                      input logic [2:0] alu, input logic [1:0] mux, input logic rf);
      return {st, c, alu, mux, rf, (st == 3'd6), fbe, fill};
   endfunction

   task automatic step(input logic rdy, input logic [16:0] e, input string nm);
      exp_t x;
      @(posedge clk);
      #1;
      rst_n        = rst_drv;
      instr_in     = cur_i;
      z_in         = cur_z;
      mem_ready_in = rdy;
      x.v  = e;
      x.nm = nm;
      q.push_back(x);
   endtask

   task automatic plain(input logic [2:0] st, input string nm);
      step(1'b1, ev(st, 5'b00000, 3'b000, 2'b11, 1'b0), nm);
   endtask

   task automatic fetch(input logic [15:0] ins, input logic rdy, input string nm);
      cur_i = ins;
      step(rdy, ev(3'd1, rdy ? 5'b10110 : 5'b10000, 3'b000, 2'b11, 1'b0), nm);
   endtask

   task automatic do_reset();
      rst_drv = 1'b0;
      fbe     = 1'b0;
      fill    = 1'b0;
      plain(3'd0, "rst0");
      plain(3'd0, "rst1");
      rst_drv = 1'b1;
      plain(3'd0, "rel_idle");
   endtask

   // Monitor: compare every queued expectation against the outputs mid-cycle.
   always @(negedge clk) begin : mon
      exp_t e;
      if (q.size() != 0) begin
         e = q.pop_front();
         checks++;
         if (act !== e.v) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", e.nm, act, e.v);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      rst_n = 1'b0; instr_in = 16'h0000; z_in = 1'b0; mem_ready_in = 1'b0;
      do_reset();
      // ADD / SUB / XOR through WB
      fetch(16'h1234, 1'b1, "add_f");
      plain(3'd2, "add_d");
      step(1'b1, ev(3'd3, 5'b0, 3'b000, 2'b11, 1'b0), "add_e");
      step(1'b1, ev(3'd5, 5'b0, 3'b000, 2'b00, 1'b1), "add_wb");
      fetch(16'h2000, 1'b1, "sub_f");
      plain(3'd2, "sub_d");
      step(1'b1, ev(3'd3, 5'b0, 3'b001, 2'b11, 1'b0), "sub_e");
      step(1'b1, ev(3'd5, 5'b0, 3'b001, 2'b00, 1'b1), "sub_wb");
      fetch(16'h5abc, 1'b1, "xor_f");
      plain(3'd2, "xor_d");
      step(1'b1, ev(3'd3, 5'b0, 3'b100, 2'b11, 1'b0), "xor_e");
      step(1'b1, ev(3'd5, 5'b0, 3'b100, 2'b00, 1'b1), "xor_wb");
      // LD with 3 wait cycles
      fetch(16'h7000, 1'b1, "ld_f");
      plain(3'd2, "ld_d");
      plain(3'd3, "ld_e");
      for (int i = 0; i < 3; i++) step(1'b0, ev(3'd4, 5'b10000, 3'b0, 2'b11, 1'b0), "ld_mwait");
      step(1'b1, ev(3'd4, 5'b10000, 3'b0, 2'b11, 1'b0), "ld_mrdy");
      step(1'b1, ev(3'd5, 5'b0, 3'b0, 2'b01, 1'b1), "ld_wb");
      // ST: write request then straight back to FETCH
      fetch(16'h8000, 1'b1, "st_f");
      plain(3'd2, "st_d");
      plain(3'd3, "st_e");
      step(1'b1, ev(3'd4, 5'b11000, 3'b0, 2'b11, 1'b0), "st_m");
      fetch(16'h6000, 1'b1, "ldi_f");
      plain(3'd2, "ldi_d");
      plain(3'd3, "ldi_e");
      step(1'b1, ev(3'd5, 5'b0, 3'b0, 2'b10, 1'b1), "ldi_wb");
      // Branches
      cur_z = 1'b1;
      fetch(16'hA123, 1'b1, "jz1_f");
      plain(3'd2, "jz1_d");
      step(1'b1, ev(3'd3, 5'b00001, 3'b0, 2'b11, 1'b0), "jz1_e");
      cur_z = 1'b0;
      fetch(16'hA123, 1'b1, "jz0_f");
      plain(3'd2, "jz0_d");
      plain(3'd3, "jz0_e");
      fetch(16'h9000, 1'b1, "jmp_f");
      plain(3'd2, "jmp_d");
      step(1'b1, ev(3'd3, 5'b00001, 3'b0, 2'b11, 1'b0), "jmp_e");
      fetch(16'h0000, 1'b1, "nop_f");
      plain(3'd2, "nop_d");
      plain(3'd3, "nop_e");
      // Illegal opcode
      fetch(16'hC000, 1'b1, "ill_f");
      plain(3'd2, "ill_d");
      plain(3'd3, "ill_e");
`ifdef ILLEGAL_TRAP_EN
      fill = 1'b1;
      plain(3'd6, "ill_halt0");
      plain(3'd6, "ill_halt1");
`else
      fetch(16'h0000, 1'b1, "ill_back_f");
      plain(3'd2, "ill_back_d");
`endif
      do_reset();
      // Ready on the 5th fetch cycle beats the timeout
      for (int i = 0; i < 4; i++) fetch(16'h7000, 1'b0, "to_fwait");
      fetch(16'h7000, 1'b1, "to_f5rdy");
      plain(3'd2, "to_d");
      plain(3'd3, "to_e");
      for (int i = 0; i < 5; i++) step(1'b0, ev(3'd4, 5'b10000, 3'b0, 2'b11, 1'b0), "to_mwait");
      fbe = 1'b1;
      plain(3'd6, "to_halt0");
      plain(3'd6, "to_halt1");
      do_reset();
      // Reset asserted mid-request drops req without waiting for a clock edge
      fetch(16'h7000, 1'b0, "ar_f");
      rst_drv = 1'b0;
      plain(3'd0, "ar_async");
      rst_drv = 1'b1;
      plain(3'd0, "ar_rel");
      // HLT is absorbing
      fetch(16'hF000, 1'b1, "hlt_f");
      plain(3'd2, "hlt_d");
      plain(3'd3, "hlt_e");
      for (int i = 0; i < 3; i++) plain(3'd6, "hlt_hold");
      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain actual=%0d required=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
